// File: rtl/fifo_pkg.sv
// Shared types and sizing helpers for the sync_fifo slice.
package fifo_pkg;

  typedef enum logic {
    STD  = 1'b0,
    FWFT = 1'b1
  } fifo_mode_e;

  // Pointer width: enough bits to address DEPTH entries (at least 1).
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Count width: enough bits to hold 0..DEPTH inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Producer/consumer bundle for sync_fifo. WIDTH and DEPTH must match the FIFO instance.
interface sync_fifo_if
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64
) ();

  logic                      wr_en;
  logic [WIDTH-1:0]          wr_data;
  logic                      rd_en;
  logic [WIDTH-1:0]          rd_data;
  logic                      rd_valid;
  logic [cnt_w(DEPTH)-1:0]   count;
  logic                      full;
  logic                      empty;
  logic                      almost_full;
  logic                      almost_empty;
  logic                      overflow;
  logic                      underflow;

  // Client side: drives requests, observes data and status.
  modport master (
    output wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, count, full, empty,
           almost_full, almost_empty, overflow, underflow
  );

  // FIFO side.
  modport slave (
    input  wr_en, wr_data, rd_en,
    output rd_data, rd_valid, count, full, empty,
           almost_full, almost_empty, overflow, underflow
  );

endinterface

// File: rtl/fifo_ram.sv
// WIDTH x DEPTH register array: one synchronous write port, one asynchronous read port, no reset.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64,
  parameter int AW    = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Store write data; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds,
// standard or first-word-fall-through read mode, and sticky error flags.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 64,
  parameter int AF_THRESH = DEPTH - 4,
  parameter int AE_THRESH = 4,
  parameter int FWFT      = 0
) (
  input logic         clk,
  input logic         rst_n,
  sync_fifo_if.slave  bus
);

  localparam fifo_mode_e    MODE     = (FWFT != 0) ? fifo_pkg::FWFT : fifo_pkg::STD;
  localparam int            PW       = ptr_w(DEPTH);
  localparam int            CW       = cnt_w(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LVL   = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_LVL   = CW'(AE_THRESH);

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             full_w;
  logic             empty_w;
  logic             wr_acc;
  logic             rd_acc;
  logic             overflow_q;
  logic             underflow_q;
  logic [WIDTH-1:0] ram_q;
  logic [WIDTH-1:0] rd_data_q;
  logic             rd_valid_q;

  assign full_w  = (count_q == CNT_FULL);
  assign empty_w = (count_q == '0);

  // Accept requests only when there is room / data.
  always_comb begin
    wr_acc = bus.wr_en && !full_w;
    rd_acc = bus.rd_en && !empty_w;
  end

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (bus.wr_data),
    .raddr (rd_ptr),
    .rdata (ram_q)
  );

  // Advance wrapping pointers and track occupancy directly from accepted requests.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_acc) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
      if (rd_acc) rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
      count_q <= count_q + CW'(wr_acc) - CW'(rd_acc);
    end
  end

  // Sticky error flags: any request against a full/empty FIFO, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.wr_en && full_w)  overflow_q  <= 1'b1;
      if (bus.rd_en && empty_w) underflow_q <= 1'b1;
    end
  end

  // Read-data register: in STD it captures the popped word; in FWFT it remembers
  // the last head shown so the output holds once the FIFO runs empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else if (MODE == fifo_pkg::STD) begin
      rd_valid_q <= rd_acc;
      if (rd_acc) rd_data_q <= ram_q;
    end else begin
      rd_valid_q <= 1'b0;
      if (!empty_w) rd_data_q <= ram_q;
    end
  end

  assign bus.rd_data      = (MODE == fifo_pkg::FWFT && !empty_w) ? ram_q : rd_data_q;
  assign bus.rd_valid     = (MODE == fifo_pkg::FWFT) ? !empty_w : rd_valid_q;
  assign bus.count        = count_q;
  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.almost_full  = (count_q >= AF_LVL);
  assign bus.almost_empty = (count_q <= AE_LVL);
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench: three sync_fifo instances (STD depth 8, FWFT depth 8,
// STD depth 5) share one stimulus stream and are compared every cycle against
// a queue-based model, with directed literal checks pinning key behaviour.
module tb_sync_fifo;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       wr_en   = 1'b0;
  logic       rd_en   = 1'b0;
  logic [7:0] wr_data = 8'h00;
  bit         started = 1'b0;

  int vectors    = 0;
  int miscompares = 0;

  sync_fifo_if #(.WIDTH(8), .DEPTH(8)) bus_a ();
  sync_fifo_if #(.WIDTH(8), .DEPTH(8)) bus_b ();
  sync_fifo_if #(.WIDTH(8), .DEPTH(5)) bus_c ();

  assign bus_a.wr_en = wr_en;  assign bus_a.wr_data = wr_data;  assign bus_a.rd_en = rd_en;
  assign bus_b.wr_en = wr_en;  assign bus_b.wr_data = wr_data;  assign bus_b.rd_en = rd_en;
  assign bus_c.wr_en = wr_en;  assign bus_c.wr_data = wr_data;  assign bus_c.rd_en = rd_en;

  sync_fifo #(.WIDTH(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(4), .FWFT(0))
    u_std (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
  sync_fifo #(.WIDTH(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1))
    u_fwft (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));
  sync_fifo #(.WIDTH(8), .DEPTH(5), .AF_THRESH(4), .AE_THRESH(1), .FWFT(0))
    u_odd (.clk(clk), .rst_n(rst_n), .bus(bus_c.slave));

  initial forever #5 clk = ~clk;

  // Model configuration per instance.
  string tags [3] = '{"std", "fwft", "odd"};
  int    dep  [3] = '{8, 8, 5};
  int    afl  [3] = '{6, 6, 4};
  int    ael  [3] = '{4, 2, 1};
  int    fw   [3] = '{0, 1, 0};

  // Model state.
  logic [7:0] mq  [3][$];
  int         movf [3];
  int         mudf [3];
  int         mrv  [3];
  int         mrd  [3];
  int         mlast[3];

  // Model update on each rising edge from the inputs presented before it.
  initial forever begin
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        mq[i].delete();
        movf[i] = 0; mudf[i] = 0; mrv[i] = 0; mrd[i] = 0; mlast[i] = 0;
      end else begin
        int  n;
        bit  is_full, is_empty, wa, ra;
        n        = mq[i].size();
        is_full  = (n == dep[i]);
        is_empty = (n == 0);
        wa       = wr_en && !is_full;
        ra       = rd_en && !is_empty;
        if (wr_en && is_full)  movf[i] = 1;
        if (rd_en && is_empty) mudf[i] = 1;
        if (!is_empty) mlast[i] = mq[i][0];
        if (fw[i] == 0) mrv[i] = ra ? 1 : 0;
        if (ra) begin
          logic [7:0] h;
          h = mq[i].pop_front();
          if (fw[i] == 0) mrd[i] = h;
        end
        if (wa) mq[i].push_back(wr_data);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic check_inst(input int i, input int cnt, input int f, input int e,
                            input int af, input int ae, input int ov, input int ud,
                            input int rv, input int rd);
    int n;
    int exp_rd;
    n = mq[i].size();
    if (fw[i] != 0) exp_rd = (n != 0) ? int'(mq[i][0]) : mlast[i];
    else            exp_rd = mrd[i];
    chk({tags[i], ".count"},        cnt, n);
    chk({tags[i], ".full"},         f,   (n == dep[i]) ? 1 : 0);
    chk({tags[i], ".empty"},        e,   (n == 0) ? 1 : 0);
    chk({tags[i], ".almost_full"},  af,  (n >= afl[i]) ? 1 : 0);
    chk({tags[i], ".almost_empty"}, ae,  (n <= ael[i]) ? 1 : 0);
    chk({tags[i], ".overflow"},     ov,  movf[i]);
    chk({tags[i], ".underflow"},    ud,  mudf[i]);
    chk({tags[i], ".rd_valid"},     rv,  (fw[i] != 0) ? ((n != 0) ? 1 : 0) : mrv[i]);
    chk({tags[i], ".rd_data"},      rd,  exp_rd);
  endtask

  // Compare every DUT against the model on the falling edge.
  initial forever begin
    @(negedge clk);
    if (started) begin
      check_inst(0, int'(bus_a.count), int'(bus_a.full), int'(bus_a.empty), int'(bus_a.almost_full),
                 int'(bus_a.almost_empty), int'(bus_a.overflow), int'(bus_a.underflow),
                 int'(bus_a.rd_valid), int'(bus_a.rd_data));
      check_inst(1, int'(bus_b.count), int'(bus_b.full), int'(bus_b.empty), int'(bus_b.almost_full),
                 int'(bus_b.almost_empty), int'(bus_b.overflow), int'(bus_b.underflow),
                 int'(bus_b.rd_valid), int'(bus_b.rd_data));
      check_inst(2, int'(bus_c.count), int'(bus_c.full), int'(bus_c.empty), int'(bus_c.almost_full),
                 int'(bus_c.almost_empty), int'(bus_c.overflow), int'(bus_c.underflow),
                 int'(bus_c.rd_valid), int'(bus_c.rd_data));
    end
  end

  // Present inputs, let one rising edge pass, then settle.
  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic rs);
    wr_en = w; wr_data = d; rd_en = r; rst_n = rs;
    @(posedge clk);
    #2;
  endtask

  initial begin
    // Reset held for two cycles.
    step(1'b0, 8'h00, 1'b0, 1'b0);
    started = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("rst.count",        int'(bus_a.count), 0);
    chk("rst.empty",        int'(bus_a.empty), 1);
    chk("rst.almost_empty", int'(bus_a.almost_empty), 1);
    chk("rst.rd_valid",     int'(bus_a.rd_valid), 0);
    chk("rst.overflow",     int'(bus_a.overflow), 0);
    chk("rst.underflow",    int'(bus_a.underflow), 0);

    // Fill 0x01..0x08, then overflow with 0x09.
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 8'(k), 1'b0, 1'b1);
      if (k == 5) chk("fill.af_before", int'(bus_a.almost_full), 0);
      if (k == 6) chk("fill.af_at6",    int'(bus_a.almost_full), 1);
      if (k == 7) chk("fill.full_at7",  int'(bus_a.full), 0);
    end
    chk("fill.full",  int'(bus_a.full), 1);
    chk("fill.count", int'(bus_a.count), 8);
    step(1'b1, 8'h09, 1'b0, 1'b1);
    chk("ovf.flag",  int'(bus_a.overflow), 1);
    chk("ovf.count", int'(bus_a.count), 8);

    // Drain in standard mode; each word appears one cycle after rd_en.
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, 8'h00, 1'b1, 1'b1);
      chk("drain.rd_data",  int'(bus_a.rd_data), k);
      chk("drain.rd_valid", int'(bus_a.rd_valid), 1);
    end
    chk("drain.empty", int'(bus_a.empty), 1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("drain.valid_drop", int'(bus_a.rd_valid), 0);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    chk("udf.flag",     int'(bus_a.underflow), 1);
    chk("udf.rd_valid", int'(bus_a.rd_valid), 0);

    // Simultaneous read/write at count 4 across pointer wrap.
    step(1'b0, 8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b1, 8'(8'h40 + k), 1'b0, 1'b1);
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 8'(8'h50 + k), 1'b1, 1'b1);
      chk("rw.count",   int'(bus_a.count), 4);
      chk("rw.rd_data", int'(bus_a.rd_data), (k < 4) ? (8'h40 + k) : (8'h50 + k - 4));
      chk("rw.errors",  int'(bus_a.overflow) + int'(bus_a.underflow), 0);
    end

    // FWFT: written word appears without rd_en, pop empties, output holds.
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'hA5, 1'b0, 1'b1);
    chk("fwft.rd_valid", int'(bus_b.rd_valid), 1);
    chk("fwft.rd_data",  int'(bus_b.rd_data), 8'hA5);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("fwft.still", int'(bus_b.rd_data), 8'hA5);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    chk("fwft.pop_empty", int'(bus_b.empty), 1);
    chk("fwft.pop_valid", int'(bus_b.rd_valid), 0);
    chk("fwft.pop_hold",  int'(bus_b.rd_data), 8'hA5);

    // Odd depth, reset with count 3 and requests in flight.
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h11, 1'b0, 1'b1);
    step(1'b1, 8'h22, 1'b0, 1'b1);
    step(1'b1, 8'h33, 1'b0, 1'b1);
    chk("odd.count3", int'(bus_c.count), 3);
    step(1'b1, 8'h44, 1'b1, 1'b0);
    chk("odd.rst_count", int'(bus_c.count), 0);
    chk("odd.rst_empty", int'(bus_c.empty), 1);
    for (int k = 1; k <= 3; k++) step(1'b1, 8'(8'h60 + k), 1'b0, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      step(1'b0, 8'h00, 1'b1, 1'b1);
      chk("odd.readback", int'(bus_c.rd_data), 8'h60 + k);
    end

    // Randomized traffic in biased phases with occasional resets.
    for (int p = 0; p < 4; p++) begin
      int wp, rp;
      case (p)
        0:       begin wp = 80; rp = 20; end
        1:       begin wp = 20; rp = 80; end
        2:       begin wp = 50; rp = 50; end
        default: begin wp = 95; rp = 95; end
      endcase
      for (int c = 0; c < 150; c++) begin
        step(($urandom_range(99) < wp) ? 1'b1 : 1'b0, 8'($urandom),
             ($urandom_range(99) < rp) ? 1'b1 : 1'b0,
             ($urandom_range(99) == 0) ? 1'b0 : 1'b1);
      end
    end

    step(1'b0, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, parametrised FIFO: the next generation of the team's basic FIFO. It adds an occupancy count, programmable almost-full/almost-empty thresholds, a selectable first-word-fall-through (FWFT) read mode, and sticky overflow/underflow error flags. It buffers data between producer and consumer blocks in the same `clk` domain.

## Interface
- `WIDTH`, 8: data width in bits, ≥1.
- `DEPTH`, 64: number of entries, ≥2; any integer, not limited to powers of two.
- `AF_THRESH`, DEPTH-4: `almost_full` asserts when count ≥ AF_THRESH; range 1..DEPTH.
- `AE_THRESH`, 4: `almost_empty` asserts when count ≤ AE_THRESH; range 0..DEPTH-1.
- `FWFT`, 0: 0 = standard registered read; 1 = first-word-fall-through.
- `clk`, in, 1: clock; all logic on rising edge.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `wr_en`, in, 1: write request.
- `wr_data`, in, WIDTH: write data.
- `rd_en`, in, 1: read request (in FWFT mode, this is the pop/acknowledge).
- `rd_data`, out, WIDTH: read data.
- `rd_valid`, out, 1: `rd_data` is valid.
- `count`, out, $clog2(DEPTH+1): current occupancy.
- `full`, `empty`, `almost_full`, `almost_empty`, out, 1 each: status flags.
- `overflow`, `underflow`, out, 1 each: sticky error flags.

## Operation
- Write acceptance: write accepted iff `wr_en && !full`. An accepted write stores `wr_data` at `wr_ptr`. `wr_ptr` wraps from DEPTH-1 to 0.
- Read acceptance: read accepted iff `rd_en && !empty`. An accepted read advances `rd_ptr`, which wraps from DEPTH-1 to 0.
- Simultaneous accepted read and write: `count` is unchanged, and both pointers advance.
- Full with `wr_en && rd_en`: only the read is accepted, the write is rejected, and `overflow` sets.
- Empty with `wr_en && rd_en`: only the write is accepted, the read is rejected, and `underflow` sets.
- `overflow` sets on `wr_en && full`. `underflow` sets on `rd_en && empty`. Both clear only on reset.
- Count-derived flags: `full` = (count==DEPTH), `empty` = (count==0), `almost_full` = (count≥AF_THRESH), `almost_empty` = (count≤AE_THRESH).
- Count update: `count` is registered and is next-count = count + wr_acc − rd_acc. It is never computed from pointer difference.
- Standard mode (`FWFT`=0): an accepted read loads `rd_data` from `mem[rd_ptr]` on the next edge and pulses `rd_valid` for one cycle. `rd_data` holds its last value otherwise.
- FWFT mode (`FWFT`=1):
  - `rd_data` = `mem[rd_ptr]` whenever `!empty`, and `rd_valid` = `!empty`.
  - `rd_en` pops the head, and the next entry appears on the cycle after the pop edge.
  - With `empty`, `rd_data` holds its last value.
- Reset: pointers, `count`, and error flags are cleared; stored contents are discarded and the memory array is not reset.
- Reset mid-operation: the FIFO is empty on the cycle after reset; in-flight writes and reads in the reset cycle are ignored.

## Timing
- Reset values: `count`=0, `empty`=1, `almost_empty`=1, `full`=0, `almost_full`=0, `overflow`=0, `underflow`=0, `rd_valid`=0, `rd_data`=0.
- Write-to-status latency: a write accepted at edge N is reflected in `count` and flags after edge N.
- Standard-mode read latency: `rd_en` sampled at edge N gives `rd_data`/`rd_valid` valid after edge N (one cycle).
- FWFT write-to-output latency: a write into an empty FIFO at edge N gives `rd_valid`=1 with that data after edge N.
- Flag registration: all flags are registered or pure decodes of registered `count`; no input-to-output combinational path except the FWFT `rd_data` mux from `rd_ptr`.

## Structure
- `fifo_pkg`: holds the `fifo_mode_e` enum (STD, FWFT) and the `ptr_w`/`cnt_w` helper functions.
- `fifo_ram` sub-module: WIDTH×DEPTH register array, one write port, one asynchronous read port, no reset.
- `sync_fifo` top: owns the pointers, count, flags, and read-data register.

## Test plan
- Reset: DEPTH=8, hold rst_n=0 for 2 cycles → `count`=0, `empty`=1, `almost_empty`=1, `rd_valid`=0, `overflow`=`underflow`=0.
- Fill and overflow: DEPTH=8, AF_THRESH=6, write 0x01..0x08 → `almost_full` rises after the 6th write and `full` after the 8th; a 9th write (0x09) sets `overflow` and `count` stays 8.
- Drain and underflow: standard mode, read 8 times → `rd_data` is 0x01..0x08, each one cycle after `rd_en`; `empty` after the last read; a further `rd_en` sets `underflow`.
- Simultaneous read/write: count=4, hold `wr_en`/`rd_en` for 20 cycles → `count` stays 4, data order is preserved across pointer wrap, no error flags.
- FWFT mode: write 0xA5 into an empty FIFO → the next cycle shows `rd_valid`=1, `rd_data`=0xA5 without `rd_en`; pop → `empty`=1.
- Odd depth and mid-operation reset: DEPTH=5, count=3, assert rst_n=0 for 1 cycle → `count`=0, `empty`=1; subsequent writes read back correctly from entry 0.
